// File: rtl/uart_alu_interface.sv
// uart_alu_interface
// Byte-level calculator between a UART receiver and a UART transmitter.
// It collects three received bytes (operand A, operand B, opcode), computes
// the result with an internal ALU and hands the result byte to the
// transmitter through a start/done handshake.
//
// Ports:
//   CLK      in  1      - clock, all state updates on posedge
//   RESET    in  1      - synchronous active-high reset
//   RX_DONE  in  1      - one-cycle pulse from the receiver, DIN valid
//   DIN      in  N_BIT  - received byte
//   TX_DONE  in  1      - one-cycle pulse from the transmitter (stop bit done)
//   TX_START out 1      - one-cycle request to the transmitter
//   TX_DIN   out N_BIT  - registered result byte, stable until TX_DONE
//   ERR      out 1      - one-cycle pulse on an invalid opcode
//   STATE    out 3      - current FSM state (debug / LEDs)
module uart_alu_interface #(
  parameter int N_BIT = 8,
  parameter int N_OP  = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RX_DONE,
  input  logic [N_BIT-1:0] DIN,
  input  logic             TX_DONE,
  output logic             TX_START,
  output logic [N_BIT-1:0] TX_DIN,
  output logic             ERR,
  output logic [2:0]       STATE
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam logic [N_OP-1:0] OP_ADD = N_OP'(6'b100000);
  localparam logic [N_OP-1:0] OP_SUB = N_OP'(6'b100010);
  localparam logic [N_OP-1:0] OP_AND = N_OP'(6'b100100);
  localparam logic [N_OP-1:0] OP_OR  = N_OP'(6'b100101);
  localparam logic [N_OP-1:0] OP_XOR = N_OP'(6'b100110);
  localparam logic [N_OP-1:0] OP_NOR = N_OP'(6'b100111);
  localparam logic [N_OP-1:0] OP_SRA = N_OP'(6'b000011);
  localparam logic [N_OP-1:0] OP_SRL = N_OP'(6'b000010);

  state_t             state;
  logic [N_BIT-1:0]   a;
  logic [N_BIT-1:0]   b;
  logic [N_BIT-1:0]   res;
  logic               tx_start;
  logic               err;

  logic [N_OP-1:0]    op;
  logic [N_BIT-1:0]   alu_res;
  logic               op_valid;
  logic               shift_big;

  // Only the low N_OP bits of the opcode byte matter; the rest are ignored.
  assign op = DIN[N_OP-1:0];

  // Shift amounts of N_BIT or more saturate: sign fill for SRA, zero for SRL.
  assign shift_big = (32'(b) >= 32'(N_BIT));

  // ALU and opcode decode, evaluated every cycle against the live DIN byte;
  // the FSM only uses the outcome in WAIT_OP when RX_DONE is high.
  always_comb begin
    alu_res  = '0;
    op_valid = 1'b1;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SRA:  alu_res = shift_big ? {N_BIT{a[N_BIT-1]}}
                                   : N_BIT'($signed(a) >>> b);
      OP_SRL:  alu_res = shift_big ? '0 : (a >> b);
      default: op_valid = 1'b0;
    endcase
  end

  // Control FSM. TX_START and ERR are registered pulses: they are set on
  // the edge that enters SEND (or rejects the opcode) and cleared by the
  // default assignment on the following edge. Bytes arriving in SEND or
  // WAIT_TX fall through untouched, so they are simply dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= WAIT_A;
      a        <= '0;
      b        <= '0;
      res      <= '0;
      tx_start <= 1'b0;
      err      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      err      <= 1'b0;
      case (state)
        WAIT_A: begin
          if (RX_DONE) begin
            a     <= DIN;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (RX_DONE) begin
            b     <= DIN;
            state <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (RX_DONE) begin
            if (op_valid) begin
              res      <= alu_res;
              tx_start <= 1'b1;
              state    <= SEND;
            end else begin
              err      <= 1'b1;
              state    <= WAIT_A;
            end
          end
        end
        SEND: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (TX_DONE) begin
            state <= WAIT_A;
          end
        end
        default: begin
          state <= WAIT_A;
        end
      endcase
    end
  end

  assign TX_START = tx_start;
  assign TX_DIN   = res;
  assign ERR      = err;
  assign STATE    = state;

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface
// Self-checking bench for uart_alu_interface: a table of directed calculator
// transactions, hand-written multi-cycle corner cases (busy drop, reset
// mid-operation, simultaneous pulses) and randomized transactions checked
// against an arithmetic reference model.
module tb_uart_alu_interface;

  logic       clk;
  logic       reset;
  logic       rx_done;
  logic [7:0] din;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       err;
  logic [2:0] state;

  int pass_count;
  int check_count;
  int start_count;
  int err_count;
  logic [7:0] last_res;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp;
    logic       is_err;
    string      name;
  } vec_t;

  vec_t vecs[11];

  uart_alu_interface #(.N_BIT(8), .N_OP(6)) dut (
    .CLK      (clk),
    .RESET    (reset),
    .RX_DONE  (rx_done),
    .DIN      (din),
    .TX_DONE  (tx_done),
    .TX_START (tx_start),
    .TX_DIN   (tx_din),
    .ERR      (err),
    .STATE    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count handshake pulses as the DUT presents them on each rising edge.
  always @(posedge clk) begin
    if (tx_start) start_count <= start_count + 1;
    if (err) err_count <= err_count + 1;
  end

  // Reference calculator: plain integer arithmetic on the byte values.
  // Returns {valid, result}.
  function automatic logic [8:0] refModel(input logic [7:0] a_in,
                                          input logic [7:0] b_in,
                                          input logic [7:0] op_in);
    int ia;
    int ib;
    int sa;
    int r;
    int p;
    logic ok;
    ia = 32'(a_in);
    ib = 32'(b_in);
    ok = 1'b1;
    r  = 0;
    case (op_in[5:0])
      6'b100000: r = (ia + ib) % 256;
      6'b100010: r = (ia - ib + 256) % 256;
      6'b100100: r = ia & ib;
      6'b100101: r = ia | ib;
      6'b100110: r = ia ^ ib;
      6'b100111: r = 255 - (ia | ib);
      6'b000011: begin
        sa = (ia >= 128) ? ia - 256 : ia;
        if (ib >= 8) begin
          r = (sa < 0) ? 255 : 0;
        end else begin
          p = 1 << ib;
          if (sa >= 0) r = sa / p;
          else r = -((-sa + p - 1) / p);
          r = r & 255;
        end
      end
      6'b000010: begin
        if (ib >= 8) r = 0;
        else r = ia / (1 << ib);
      end
      default: ok = 1'b0;
    endcase
    return {ok, r[7:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents one byte for one cycle. Called at a negedge; returns at the
  // next negedge with RX_DONE still high so bytes can be chained.
  task automatic applyStimulus(input logic [7:0] value);
    rx_done = 1'b1;
    din     = value;
    @(negedge clk);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, " state"},    32'(state),    32'd0);
    checkOutput({name, " tx_din"},   32'(tx_din),   32'd0);
    checkOutput({name, " tx_start"}, 32'(tx_start), 32'd0);
    checkOutput({name, " err"},      32'(err),      32'd0);
  endtask

  // One full transaction. inject: 0 none, 1 stray byte during WAIT_TX,
  // 2 stray byte in the same cycle as TX_DONE.
  task automatic runOp(input logic [7:0] a_in, input logic [7:0] b_in,
                       input logic [7:0] op_in, input logic exp_err,
                       input logic [7:0] exp_res, input int inject,
                       input string name);
    int s0;
    int e0;
    int idle;
    s0 = start_count;
    e0 = err_count;
    applyStimulus(a_in);
    applyStimulus(b_in);
    applyStimulus(op_in);
    rx_done = 1'b0;
    if (exp_err) begin
      checkOutput({name, " err pulse"},   32'(err),      32'd1);
      checkOutput({name, " err state"},   32'(state),    32'd0);
      checkOutput({name, " err no start"},32'(tx_start), 32'd0);
      checkOutput({name, " tx_din kept"}, 32'(tx_din),   32'(last_res));
      @(negedge clk);
      checkOutput({name, " err falls"},   32'(err),      32'd0);
    end else begin
      checkOutput({name, " start"},       32'(tx_start), 32'd1);
      checkOutput({name, " send state"},  32'(state),    32'd3);
      checkOutput({name, " result"},      32'(tx_din),   32'(exp_res));
      @(negedge clk);
      checkOutput({name, " start falls"}, 32'(tx_start), 32'd0);
      checkOutput({name, " wait_tx"},     32'(state),    32'd4);
      idle = $urandom_range(0, 4);
      repeat (idle) @(negedge clk);
      if (inject == 1) begin
        rx_done = 1'b1;
        din     = 8'hAA;
        @(negedge clk);
        rx_done = 1'b0;
        checkOutput({name, " busy ignores rx"}, 32'(state), 32'd4);
      end
      checkOutput({name, " result held"}, 32'(tx_din), 32'(exp_res));
      tx_done = 1'b1;
      if (inject == 2) begin
        rx_done = 1'b1;
        din     = 8'h55;
      end
      @(negedge clk);
      tx_done = 1'b0;
      rx_done = 1'b0;
      checkOutput({name, " back to idle"}, 32'(state), 32'd0);
      checkOutput({name, " result after done"}, 32'(tx_din), 32'(exp_res));
      last_res = exp_res;
    end
    checkOutput({name, " start pulses"}, 32'(start_count - s0), exp_err ? 32'd0 : 32'd1);
    checkOutput({name, " err pulses"},   32'(err_count - e0),   exp_err ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [7:0] ops[8];
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rop;
    logic [8:0] m;
    int s0;

    pass_count  = 0;
    check_count = 0;
    start_count = 0;
    err_count   = 0;
    last_res    = 8'h00;
    reset       = 1'b1;
    rx_done     = 1'b0;
    din         = 8'h00;
    tx_done     = 1'b0;

    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0, "ADD"};
    vecs[1]  = '{8'h03, 8'h05, 8'hE2, 8'hFE, 1'b0, "SUB wrap masked"};
    vecs[2]  = '{8'h80, 8'h02, 8'h03, 8'hE0, 1'b0, "SRA"};
    vecs[3]  = '{8'h80, 8'h02, 8'h02, 8'h20, 1'b0, "SRL"};
    vecs[4]  = '{8'h80, 8'h09, 8'h03, 8'hFF, 1'b0, "SRA by 9"};
    vecs[5]  = '{8'h01, 8'h02, 8'h3F, 8'h00, 1'b1, "invalid op"};
    vecs[6]  = '{8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0, "OR"};
    vecs[7]  = '{8'h0F, 8'hFF, 8'h26, 8'hF0, 1'b0, "XOR"};
    vecs[8]  = '{8'h0F, 8'hF0, 8'h27, 8'h00, 1'b0, "NOR"};
    vecs[9]  = '{8'hF0, 8'h08, 8'h02, 8'h00, 1'b0, "SRL by 8"};
    vecs[10] = '{8'h70, 8'h03, 8'h03, 8'h0E, 1'b0, "SRA positive"};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkResetState("power-on reset");

    // TX_DONE while idle must not move the FSM.
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checkOutput("tx_done idle ignored", 32'(state), 32'd0);

    for (int i = 0; i < 11; i++) begin
      runOp(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].is_err, vecs[i].exp, 0,
            vecs[i].name);
    end

    // Busy drop: stray 0xAA in WAIT_TX must not become operand A.
    runOp(8'h05, 8'h06, 8'h20, 1'b0, 8'h0B, 1, "busy drop");
    runOp(8'h04, 8'h04, 8'h24, 1'b0, 8'h04, 0, "AND after drop");

    // Byte arriving together with TX_DONE is dropped.
    runOp(8'h01, 8'h01, 8'h20, 1'b0, 8'h02, 2, "done+rx same cycle");
    runOp(8'h09, 8'h01, 8'h22, 1'b0, 8'h08, 0, "SUB after drop");

    // TX_DONE in WAIT_B is ignored.
    applyStimulus(8'h07);
    rx_done = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checkOutput("tx_done in wait_b ignored", 32'(state), 32'd1);

    // Reset after the second byte discards the operands.
    applyStimulus(8'h33);
    s0 = start_count;
    rx_done = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetState("reset mid-op");
    last_res = 8'h00;
    @(negedge clk);
    checkOutput("reset mid-op no start", 32'(start_count - s0), 32'd0);
    runOp(8'h10, 8'h01, 8'h20, 1'b0, 8'h11, 0, "ADD after reset");

    // Reset during WAIT_TX abandons the transfer.
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h20);
    rx_done = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset wait_tx", 32'(state), 32'd4);
    s0 = start_count;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetState("reset in wait_tx");
    last_res = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset in wait_tx no start", 32'(start_count - s0), 32'd0);

    // Reset and RX_DONE together: reset wins, byte dropped.
    reset   = 1'b1;
    rx_done = 1'b1;
    din     = 8'h77;
    @(negedge clk);
    reset   = 1'b0;
    rx_done = 1'b0;
    checkResetState("reset with rx");
    runOp(8'h01, 8'h02, 8'h20, 1'b0, 8'h03, 0, "ADD after reset+rx");

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      if ($urandom_range(0, 7) == 0) rop = 8'($urandom);
      else rop = {2'($urandom), ops[$urandom_range(0, 7)][5:0]};
      m = refModel(ra, rb, rop);
      runOp(ra, rb, rop, ~m[8], m[7:0], 0, $sformatf("random %0d", i));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
